// File: rtl/ex_stage.sv
// ex_stage: execute stage of the Osiris I RV32E pipeline.
// Forwarding muxes, single-cycle ALU, branch resolution and target, and an
// iterative 32-step multiply/divide unit that stalls the pipeline while busy.
// Ports: clk/rst; ID/EX operands, immediate, PC; control (jump, branch,
// alu_src, addr_src, alu_ctrl, funct3, forward selects); MEM/WB forwarding
// values; outputs ALU result, store data, PC target, PC redirect, stall.
module ex_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_rs1_EX,
  input  logic [DATA_WIDTH-1:0] i_rs2_EX,
  input  logic [DATA_WIDTH-1:0] i_imm_ex_EX,
  input  logic [DATA_WIDTH-1:0] i_pc_EX,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4_EX,
  input  logic                  i_jump_EX,
  input  logic                  i_branch_EX,
  input  logic                  i_alu_src_EX,
  input  logic                  i_addr_src_EX,
  input  logic [4:0]            i_alu_ctrl_EX,
  input  logic [2:0]            i_funct3_EX,
  input  logic [1:0]            i_forward_a_EX,
  input  logic [1:0]            i_forward_b_EX,
  input  logic [DATA_WIDTH-1:0] i_alu_result_MEM,
  input  logic [DATA_WIDTH-1:0] i_result_WB,
  output logic [DATA_WIDTH-1:0] o_alu_result_EX,
  output logic [DATA_WIDTH-1:0] o_write_data_EX,
  output logic [DATA_WIDTH-1:0] o_pc_target_EX,
  output logic                  o_pc_src_EX,
  output logic                  o_stall_EX
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

  md_state_t             r_state;
  logic [4:0]            r_count;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_opb;
  logic [2:0]            r_op;
  logic                  r_neg_a;
  logic                  r_neg_b;

  logic [DATA_WIDTH-1:0] w_src_a, w_fwd_b, w_src_b, w_alu, w_md_result;
  logic [DATA_WIDTH-1:0] w_target_sum, w_mag_a, w_mag_b, w_quo, w_rem;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH:0]   w_mul_sum, w_div_rem, w_div_diff;
  logic                  w_is_md, w_a_signed, w_b_signed, w_taken;
  logic                  w_unused;

  // PC+4 is consumed downstream for link values, not in this stage.
  assign w_unused = ^i_pc_plus4_EX;

  always_comb begin
    w_src_a = i_rs1_EX;
    case (i_forward_a_EX)
      2'b01:   w_src_a = i_result_WB;
      2'b10:   w_src_a = i_alu_result_MEM;
      default: w_src_a = i_rs1_EX;
    endcase
    w_fwd_b = i_rs2_EX;
    case (i_forward_b_EX)
      2'b01:   w_fwd_b = i_result_WB;
      2'b10:   w_fwd_b = i_alu_result_MEM;
      default: w_fwd_b = i_rs2_EX;
    endcase
  end

  assign w_src_b         = i_alu_src_EX ? i_imm_ex_EX : w_fwd_b;
  assign o_write_data_EX = w_fwd_b;

  always_comb begin
    w_alu = '0;
    case (i_alu_ctrl_EX)
      5'd0:    w_alu = w_src_a + w_src_b;
      5'd1:    w_alu = w_src_a - w_src_b;
      5'd2:    w_alu = w_src_a & w_src_b;
      5'd3:    w_alu = w_src_a | w_src_b;
      5'd4:    w_alu = w_src_a ^ w_src_b;
      5'd5:    w_alu = w_src_a << w_src_b[4:0];
      5'd6:    w_alu = w_src_a >> w_src_b[4:0];
      5'd7:    w_alu = $signed(w_src_a) >>> w_src_b[4:0];
      5'd8:    w_alu = {{(DATA_WIDTH-1){1'b0}}, $signed(w_src_a) < $signed(w_src_b)};
      5'd9:    w_alu = {{(DATA_WIDTH-1){1'b0}}, w_src_a < w_src_b};
      5'd10:   w_alu = w_src_b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (i_funct3_EX)
      3'b000:  w_taken = (w_src_a == w_fwd_b);
      3'b001:  w_taken = (w_src_a != w_fwd_b);
      3'b100:  w_taken = ($signed(w_src_a) <  $signed(w_fwd_b));
      3'b101:  w_taken = ($signed(w_src_a) >= $signed(w_fwd_b));
      3'b110:  w_taken = (w_src_a <  w_fwd_b);
      3'b111:  w_taken = (w_src_a >= w_fwd_b);
      default: w_taken = 1'b0;
    endcase
  end

  assign o_pc_src_EX  = i_jump_EX | (i_branch_EX & w_taken);
  assign w_target_sum = (i_addr_src_EX ? w_src_a : i_pc_EX) + i_imm_ex_EX;
  assign o_pc_target_EX = {w_target_sum[DATA_WIDTH-1:1], w_target_sum[0] & ~i_addr_src_EX};

  assign w_is_md = i_alu_ctrl_EX[4] & ~i_alu_ctrl_EX[3];

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (i_alu_ctrl_EX[2:0])
      3'd1, 3'd4, 3'd6: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'd2:             w_a_signed = 1'b1;
      default:          ;
    endcase
  end

  assign w_mag_a = (w_a_signed & w_src_a[DATA_WIDTH-1]) ? -w_src_a : w_src_a;
  assign w_mag_b = (w_b_signed & w_src_b[DATA_WIDTH-1]) ? -w_src_b : w_src_b;

  // Multiply: r_lo holds the multiplier and shifts out as product bits enter.
  // Divide: {r_hi, r_lo} is {partial remainder, dividend/quotient}.
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  assign w_div_rem  = {r_hi, r_lo[DATA_WIDTH-1]};
  assign w_div_diff = w_div_rem - {1'b0, r_opb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opb   <= '0;
      r_op    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_md) begin
            r_op    <= i_alu_ctrl_EX[2:0];
            r_neg_a <= w_a_signed & w_src_a[DATA_WIDTH-1];
            r_neg_b <= w_b_signed & w_src_b[DATA_WIDTH-1];
            r_hi    <= '0;
            r_lo    <= w_mag_a;
            r_opb   <= w_mag_b;
            r_count <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_op[2]) begin
            if (w_div_diff[DATA_WIDTH]) begin
              r_hi <= w_div_rem[DATA_WIDTH-1:0];
              r_lo <= {r_lo[DATA_WIDTH-2:0], 1'b0};
            end else begin
              r_hi <= w_div_diff[DATA_WIDTH-1:0];
              r_lo <= {r_lo[DATA_WIDTH-2:0], 1'b1};
            end
          end else begin
            r_hi <= w_mul_sum[DATA_WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[DATA_WIDTH-1:1]};
          end
          r_count <= r_count + 5'd1;
          if (r_count == 5'd31) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_prod = (r_neg_a ^ r_neg_b) ? -{r_hi, r_lo} : {r_hi, r_lo};
  // A zero divisor keeps the all-ones quotient regardless of operand signs.
  assign w_quo  = ((r_neg_a ^ r_neg_b) && (r_opb != '0)) ? -r_lo : r_lo;
  assign w_rem  = r_neg_a ? -r_hi : r_hi;

  always_comb begin
    w_md_result = '0;
    case (r_op)
      3'd0:       w_md_result = w_prod[DATA_WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:       w_md_result = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
      3'd4, 3'd5: w_md_result = w_quo;
      default:    w_md_result = w_rem;
    endcase
  end

  assign o_stall_EX      = ((r_state == S_IDLE) && w_is_md) || (r_state == S_BUSY);
  assign o_alu_result_EX = (r_state == S_DONE) ? w_md_result :
                           (i_alu_ctrl_EX[4] ? '0 : w_alu);

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rs1, rs2, imm, pc, pc4, mem_v, wb_v;
  logic        jump, branch, alu_src, addr_src;
  logic [4:0]  ctrl;
  logic [2:0]  f3;
  logic [1:0]  fa, fb;
  logic [31:0] res, wdata, target;
  logic        pc_src, stall;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ex_stage #(.DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_rs1_EX         (rs1),
    .i_rs2_EX         (rs2),
    .i_imm_ex_EX      (imm),
    .i_pc_EX          (pc),
    .i_pc_plus4_EX    (pc4),
    .i_jump_EX        (jump),
    .i_branch_EX      (branch),
    .i_alu_src_EX     (alu_src),
    .i_addr_src_EX    (addr_src),
    .i_alu_ctrl_EX    (ctrl),
    .i_funct3_EX      (f3),
    .i_forward_a_EX   (fa),
    .i_forward_b_EX   (fb),
    .i_alu_result_MEM (mem_v),
    .i_result_WB      (wb_v),
    .o_alu_result_EX  (res),
    .o_write_data_EX  (wdata),
    .o_pc_target_EX   (target),
    .o_pc_src_EX      (pc_src),
    .o_stall_EX       (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(logic [1:0] s, logic [31:0] r, logic [31:0] w, logic [31:0] m);
    if (s == 2'b01) return w;
    if (s == 2'b10) return m;
    return r;
  endfunction

  function automatic logic [31:0] ref_op(logic [4:0] c, logic [31:0] a, logic [31:0] b);
    int          sa = a;
    int          sb = b;
    longint      pa, pb;
    logic [63:0] p;
    int unsigned sh = b % 32;
    case (c)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << sh;
      5'd6:  return a >> sh;
      5'd7:  return sa >>> sh;
      5'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  return (a < b) ? 32'd1 : 32'd0;
      5'd10: return b;
      5'd16: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      5'd17: begin pa = sa; pb = sb; p = pa * pb; return p[63:32]; end
      5'd18: begin pa = sa; pb = b; p = pa * pb; return p[63:32]; end
      5'd19: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      5'd20: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    int sa = a;
    int sb = b;
    case (f)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clear_inputs();
    rs1 = 0; rs2 = 0; imm = 0; pc = 0; pc4 = 4; mem_v = 0; wb_v = 0;
    jump = 0; branch = 0; alu_src = 0; addr_src = 0;
    ctrl = 0; f3 = 3'b010; fa = 0; fb = 0;
  endtask

  // Full check of every combinational output for a non-muldiv operation.
  task automatic check_comb(input string tag);
    logic [31:0] a, breg, b, base, tgt;
    a    = fwd(fa, rs1, wb_v, mem_v);
    breg = fwd(fb, rs2, wb_v, mem_v);
    b    = alu_src ? imm : breg;
    base = addr_src ? a : pc;
    tgt  = base + imm;
    if (addr_src) tgt = tgt & 32'hFFFF_FFFE;
    check({tag, "_res"},   res, ref_op(ctrl, a, b));
    check({tag, "_wdata"}, wdata, breg);
    check({tag, "_tgt"},   target, tgt);
    check({tag, "_pcsrc"}, {31'd0, pc_src}, {31'd0, jump | (branch & ref_taken(f3, a, breg))});
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
  endtask

  task automatic run_md(input string tag, input logic [4:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] sa, input logic [1:0] sb);
    logic [31:0] exp, srca, srcb;
    int unsigned cyc;
    @(posedge clk); #1;
    clear_inputs();
    fa = sa; fb = sb;
    case (sa) 2'b01: wb_v = a; 2'b10: mem_v = a; default: rs1 = a; endcase
    case (sb) 2'b01: wb_v = b; 2'b10: mem_v = b; default: rs2 = b; endcase
    srca = fwd(fa, rs1, wb_v, mem_v);
    srcb = fwd(fb, rs2, wb_v, mem_v);
    ctrl = c;
    exp  = ref_op(c, srca, srcb);
    #1;
    check({tag, "_issue_stall"}, {31'd0, stall}, 32'd1);
    check({tag, "_issue_res"}, res, 32'd0);
    cyc = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!stall) break;
      cyc++;
      // Forwarding sources move on while the unit works.
      rs1 = $urandom; rs2 = $urandom; mem_v = $urandom; wb_v = $urandom;
      if (i == 0) check({tag, "_busy_res"}, res, 32'd0);
    end
    check({tag, "_cycles"}, cyc, 32'd33);
    check(tag, res, exp);
    ctrl = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] v;
    logic [4:0]  c;
    clear_inputs();
    rst = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_res", res, 32'd0);
    ctrl = 5'd20; rs1 = 7;
    #1;
    check("rst_res_md", res, 32'd0);
    ctrl = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed ALU / forwarding / branch cases
    clear_inputs(); rs1 = 5; imm = 32'hFFFF_FFFD; alu_src = 1; ctrl = 5'd0; #2;
    check("add_imm", res, 32'd2);
    check_comb("add_imm");
    rs1 = 32'h8000_0000; imm = 31; ctrl = 5'd7; #2;
    check("sra31", res, 32'hFFFF_FFFF);
    check("sra31_stall", {31'd0, stall}, 32'd0);
    clear_inputs(); fa = 2'b10; mem_v = 7; rs1 = 1; rs2 = 2; ctrl = 5'd1; #2;
    check("fwd_mem", res, 32'd5);
    fa = 2'b01; wb_v = 9; #2;
    check("fwd_wb", res, 32'd7);
    fa = 2'b11; #2;
    check("fwd_11", res, 32'hFFFF_FFFF);
    clear_inputs(); branch = 1; f3 = 3'b110; rs1 = 1; rs2 = 32'hFFFF_FFFF;
    pc = 32'h100; imm = 32'h20; ctrl = 5'd1; #2;
    check("bltu_pcsrc", {31'd0, pc_src}, 32'd1);
    check("bltu_tgt", target, 32'h120);
    f3 = 3'b100; #2;
    check("blt_pcsrc", {31'd0, pc_src}, 32'd0);
    f3 = 3'b010; #2;
    check("f3_010_pcsrc", {31'd0, pc_src}, 32'd0);
    clear_inputs(); jump = 1; addr_src = 1; rs1 = 32'h1003; imm = 4; #2;
    check("jalr_tgt", target, 32'h1006);
    check("jalr_pcsrc", {31'd0, pc_src}, 32'd1);
    clear_inputs(); rs1 = 32'h1234; rs2 = 5; ctrl = 5'd27; #2;
    check("code27_res", res, 32'd0);
    check("code27_stall", {31'd0, stall}, 32'd0);

    // Randomized single-cycle operations
    for (int n = 0; n < 150; n++) begin
      clear_inputs();
      rs1 = $urandom; rs2 = $urandom; imm = $urandom; pc = $urandom;
      mem_v = $urandom; wb_v = $urandom;
      fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
      if (n % 4 == 0) rs2 = rs1;
      c = 5'($urandom_range(0, 23));
      ctrl = (c > 15) ? c + 5'd8 : c;
      jump = ($urandom_range(0, 7) == 0);
      branch = ~jump & $urandom_range(0, 1);
      alu_src = ~branch & $urandom_range(0, 1);
      addr_src = jump & $urandom_range(0, 1);
      f3 = 3'($urandom_range(0, 7));
      #2;
      check_comb("rnd");
    end

    // Directed multiply/divide
    run_md("mulh_m1", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00);
    run_md("mulhu_m1", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00);
    run_md("div_by0", 5'd20, 32'd7, 32'd0, 2'b00, 2'b00);
    run_md("rem_m7_2", 5'd22, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00);
    run_md("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00);
    run_md("div_neg_by0", 5'd20, 32'hFFFF_FFF9, 32'd0, 2'b00, 2'b00);
    run_md("rem_neg_by0", 5'd22, 32'hFFFF_FFF9, 32'd0, 2'b00, 2'b00);
    run_md("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2'b01);

    // Randomized multiply/divide with forwarded operands
    for (int n = 0; n < 24; n++) begin
      v = $urandom;
      case (n % 6)
        0: v = 0;
        1: v = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_md("md_rnd", 5'($urandom_range(16, 23)), $urandom, v,
             2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    // Reset in the middle of a divide
    @(posedge clk); #1;
    clear_inputs(); rs1 = 100; rs2 = 3; ctrl = 5'd20;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
    end
    ctrl = 0;
    rst = 1'b1;
    #1;
    check("midbusy_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rs1 = 40; rs2 = 2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_idle_res", res, 32'd42);
      check("post_rst_idle_stall", {31'd0, stall}, 32'd0);
    end
    run_md("post_rst_mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the Osiris I RV32E pipeline: consumes the ID/EX register outputs and produces the ALU result, store data, branch/jump target and redirect for the EX/MEM register and fetch. It contains the operand forwarding muxes, a single-cycle ALU, branch resolution, and an iterative multiply/divide unit. The multiply/divide unit stalls the pipeline through the hazard unit while it is busy.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_rs1_EX, i_rs2_EX  in  DATA_WIDTH  register-file operands.
- i_imm_ex_EX, i_pc_EX, i_pc_plus4_EX  in  DATA_WIDTH  immediate, PC, PC+4.
- i_jump_EX, i_branch_EX, i_alu_src_EX, i_addr_src_EX  in  1  control: jump, branch, srcB = imm, target base = rs1.
- i_alu_ctrl_EX  in  5  operation code.
- i_funct3_EX  in  3  branch condition.
- i_forward_a_EX, i_forward_b_EX  in  2  forward select: 00 register, 01 WB, 10 MEM, 11 same as 00.
- i_alu_result_MEM, i_result_WB  in  DATA_WIDTH  forwarding sources.
- o_alu_result_EX  out  DATA_WIDTH  result to EX/MEM.
- o_write_data_EX  out  DATA_WIDTH  forwarded rs2, used as store data.
- o_pc_target_EX  out  DATA_WIDTH  branch/jump target.
- o_pc_src_EX  out  1  redirect fetch to the target.
- o_stall_EX  out  1  multiply/divide busy; the hazard unit holds PC, IF/ID and ID/EX and bubbles EX/MEM.

## Operation
- Operands: srcA = forwarded rs1; srcB = i_alu_src_EX ? imm : forwarded rs2; o_write_data_EX = forwarded rs2.
- ALU codes (combinational, same cycle):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is srcB[4:0].
  - 8 SLT, 9 SLTU; result is zero-extended 0/1.
  - 10 PASSB (LUI).
  - 11–15 produce 0.
- Codes 16–23 go to the multiply/divide unit: 16 MUL, 17 MULH, 18 MULHSU (rs1 signed, rs2 unsigned), 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU. Codes 24–31 produce 0 with no stall.
- Target: o_pc_target_EX = (i_addr_src_EX ? srcA : pc) + imm. Bit 0 is forced to 0 when i_addr_src_EX is set (JALR).
- Branch taken by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 are never taken.
- o_pc_src_EX = jump | (branch & taken).
- Multiply/divide FSM: IDLE, BUSY, DONE.
  - IDLE: if alu_ctrl[4] and code ≤ 23, latch srcA/srcB, op and operand signs into internal registers; load 32-bit magnitudes; count = 0; go to BUSY. Operands are latched because forwarding sources change during the stall.
  - BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Go to DONE when count = 31, then count wraps to 0.
  - DONE: apply sign correction and select result; unconditionally return to IDLE.
- Sign and width rules:
  - Product is 64-bit; MUL returns the low word, MULH* the high word.
  - DIV quotient is negated if the operand signs differ; REM takes the sign of the dividend.
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend (signed and unsigned).
  - DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0; natural result, no special-case logic required.
- o_alu_result_EX shows the multiply/divide result only in DONE; during IDLE-start and BUSY it shows 0.

## Timing
- ALU ops, branch resolution and target: zero latency (combinational from inputs).
- Multiply/divide issued in cycle T (FSM IDLE): o_stall_EX is high in cycles T through T+32, i.e. 33 cycles, combinational from state/op in cycle T.
- In T+33 (DONE): o_stall_EX = 0 and the result is valid; EX/MEM captures it at the end of T+33.
- A back-to-back multiply/divide enters EX in T+34 and starts from IDLE.
- o_stall_EX never blocks o_pc_src_EX (a muldiv never branches).
- Reset (async, any state, including mid-BUSY):
  - FSM → IDLE, count = 0, internal operand/accumulator registers = 0, o_stall_EX = 0.
  - The combinational outputs follow the inputs immediately after reset deassertion.

## Test plan
- ADD srcA = 5, imm = −3 with alu_src = 1; then SRA 0x80000000 by 31 → 2, then 0xFFFFFFFF, same cycle, no stall.
- i_forward_a_EX = 10, i_alu_result_MEM = 7, rs1 = 1, SUB rs2 = 2 → 5. Repeat with 01, i_result_WB = 9 → 7. Repeat with 11 → −1.
- BLTU funct3 110, rs1 = 1, rs2 = 0xFFFFFFFF, pc = 0x100, imm = 0x20 → pc_src = 1, target 0x120. BLT with the same operands → pc_src = 0.
- JALR with rs1 = 0x1003, imm = 4 → target 0x1006, pc_src = 1.
- MULH 0xFFFFFFFF × 0xFFFFFFFF → stall for exactly 33 cycles, then 0x00000000; MULHU on the same operands → 0xFFFFFFFE.
- DIV 7 / 0 → 0xFFFFFFFF; REM −7 / 2 → −1; DIV 0x80000000 / −1 → 0x80000000. Assert rst at BUSY count 10 → stall drops immediately and FSM is IDLE.
